pipeline_hazard_ctrl: RTL and testbench

- Central stall/flush controller for the 4-stage-register pipeline: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Watches decoded fields in ID, EX and MEM; drives the PC and pipeline-register write enables, flushes and the PC source select.
- Sequences three events: load-use bubbles, taken-branch/jump flushes, and multi-cycle data-memory waits (with timeout).
- Keeps saturating performance counters and a sticky error flag.

---
 rtl/pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for a 5-stage pipeline: turns load-use hazards,
// taken redirects and slow data-memory accesses into enables, flushes and PC select.
module pipeline_hazard_ctrl #(
   parameter logic [3:0] OP_LD       = 4'b0010,
   parameter logic [3:0] OP_ST       = 4'b0011,
   parameter logic [3:0] OP_BEQ      = 4'b0110,
   parameter logic [3:0] OP_JMP      = 4'b0111,
   parameter int         MEM_TIMEOUT = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [3:0]  id_opcode,
   input  logic [2:0]  id_rs,
   input  logic [2:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic [3:0]  ex_opcode,
   input  logic [2:0]  ex_rd,
   input  logic [3:0]  mem_opcode,
   input  logic        mem_alu_zero,
   input  logic        dmem_ready,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        id_ex_write,
   output logic        ex_mem_write,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        ex_mem_flush,
   output logic        pc_src,
   output logic [1:0]  ctrl_state,
   output logic [15:0] stall_cycles,
   output logic [15:0] flush_count,
   output logic        mem_error
);

   localparam int                WCNT_W    = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_FLUSH    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       stall_cycles_q, stall_cycles_d;
   logic [15:0]       flush_count_q, flush_count_d;
   logic              mem_error_q, mem_error_d;
   logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;

   logic mem_is_ls;
   logic ev_mem_wait;
   logic ev_redirect;
   logic ev_load_use;
   logic in_wait;
   logic wait_timeout;
   logic wait_hold;
   logic stall_all;

   // The rs/rt/uses_rt fields already qualify the hazard, so the ID opcode is not decoded.
   logic id_opcode_unused;
   assign id_opcode_unused = ^id_opcode;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_comb begin
      mem_is_ls    = (mem_opcode == OP_LD) || (mem_opcode == OP_ST);
      ev_mem_wait  = mem_is_ls && !dmem_ready;
      ev_redirect  = ((mem_opcode == OP_BEQ) && mem_alu_zero) || (mem_opcode == OP_JMP);
      ev_load_use  = (ex_opcode == OP_LD) && (ex_rd != 3'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
      in_wait      = (state_q == ST_MEM_WAIT);
      // Inside MEM_WAIT only dmem_ready (or the timeout) decides; the access is already in flight.
      wait_timeout = in_wait && !dmem_ready && (wait_cnt_q == WCNT_LAST);
      wait_hold    = in_wait && !dmem_ready && !wait_timeout;
      stall_all    = wait_hold || (!in_wait && ev_mem_wait);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_RUN;
         stall_cycles_q <= 16'd0;
         flush_count_q  <= 16'd0;
         mem_error_q    <= 1'b0;
         wait_cnt_q     <= '0;
      end else begin
         state_q        <= state_d;
         stall_cycles_q <= stall_cycles_d;
         flush_count_q  <= flush_count_d;
         mem_error_q    <= mem_error_d;
         wait_cnt_q     <= wait_cnt_d;
      end
   end

   always_comb begin
      state_d        = ST_RUN;
      stall_cycles_d = stall_cycles_q;
      flush_count_d  = flush_count_q;
      mem_error_d    = mem_error_q;
      wait_cnt_d     = '0;
      if (stall_all) begin
         state_d        = ST_MEM_WAIT;
         stall_cycles_d = sat_inc(stall_cycles_q);
         wait_cnt_d     = in_wait ? wait_cnt_q + 1'b1 : '0;
      end else if (ev_redirect) begin
         state_d       = ST_FLUSH;
         flush_count_d = sat_inc(flush_count_q);
      end else if (ev_load_use) begin
         state_d        = ST_LU_STALL;
         stall_cycles_d = sat_inc(stall_cycles_q);
      end
      // A timed-out access is abandoned: release like a ready, but always resume in RUN.
      if (wait_timeout) begin
         state_d     = ST_RUN;
         mem_error_d = 1'b1;
      end
   end

   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      pc_src       = 1'b0;
      if (reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (stall_all) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
      end else if (ev_redirect) begin
         // Flushing ID/EX also squashes any dependent load-use consumer, so no bubble is needed.
         pc_src       = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end else if (ev_load_use) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_flush  = 1'b1;
      end
   end

   assign ctrl_state   = state_q;
   assign stall_cycles = stall_cycles_q;
   assign flush_count  = flush_count_q;
   assign mem_error    = mem_error_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each row drives one cycle of inputs and
// queues the expected controls/state/counters, popped and compared at the falling edge.
module tb_pipeline_hazard_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  id_opcode;
   logic [2:0]  id_rs, id_rt;
   logic        id_uses_rt;
   logic [3:0]  ex_opcode;
   logic [2:0]  ex_rd;
   logic [3:0]  mem_opcode;
   logic        mem_alu_zero;
   logic        dmem_ready;
   logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
   logic        if_id_flush, id_ex_flush, ex_mem_flush, pc_src;
   logic [1:0]  ctrl_state;
   logic [15:0] stall_cycles, flush_count;
   logic        mem_error;

   int checks   = 0;
   int failures = 0;

   localparam logic [3:0] NOP = 4'h0, LD = 4'h2, ST = 4'h3, BEQ = 4'h6, JMP = 4'h7;
   // {pc_write, if_id_write, id_ex_write, ex_mem_write, if_id_flush, id_ex_flush, ex_mem_flush, pc_src}
   localparam logic [7:0] CTL_DEF  = 8'b1111_0000;
   localparam logic [7:0] CTL_RST  = 8'b0000_1110;
   localparam logic [7:0] CTL_HOLD = 8'b0000_0000;
   localparam logic [7:0] CTL_RED  = 8'b1111_1111;
   localparam logic [7:0] CTL_LU   = 8'b0011_0100;

   always #5 clock = ~clock;

   pipeline_hazard_ctrl dut (
      .clock(clock), .reset(reset),
      .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .ex_opcode(ex_opcode), .ex_rd(ex_rd),
      .mem_opcode(mem_opcode), .mem_alu_zero(mem_alu_zero), .dmem_ready(dmem_ready),
      .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
      .ex_mem_write(ex_mem_write), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .pc_src(pc_src), .ctrl_state(ctrl_state),
      .stall_cycles(stall_cycles), .flush_count(flush_count), .mem_error(mem_error)
   );

   logic [42:0] obs;
   assign obs = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                 if_id_flush, id_ex_flush, ex_mem_flush, pc_src,
                 ctrl_state, stall_cycles, flush_count, mem_error};

   typedef struct {
      logic        rst;
      logic [3:0]  ex_op;
      logic [2:0]  ex_rd;
      logic [2:0]  rs, rt;
      logic        uses;
      logic [3:0]  mem_op;
      logic        zero, rdy;
      logic [42:0] exp;
   } row_t;

   logic [42:0] exp_q[$];
   string       name_q[$];

   function automatic row_t mk(input logic rst, input logic [3:0] ex_op, input logic [2:0] ex_rd,
                               input logic [2:0] rs, input logic [2:0] rt, input logic uses,
                               input logic [3:0] mem_op, input logic zero, input logic rdy,
                               input logic [7:0] ctl, input logic [1:0] st,
                               input int sc, input int fc, input logic err);
      row_t r;
      r.rst = rst; r.ex_op = ex_op; r.ex_rd = ex_rd; r.rs = rs; r.rt = rt; r.uses = uses;
      r.mem_op = mem_op; r.zero = zero; r.rdy = rdy;
      r.exp = {ctl, st, sc[15:0], fc[15:0], err};
      return r;
   endfunction

   function automatic row_t idle(input logic [1:0] st, input int sc, input int fc, input logic err);
      return mk(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, NOP, 1'b0, 1'b1, CTL_DEF, st, sc, fc, err);
   endfunction

   task automatic apply(input row_t r, input string nm);
      reset        = r.rst;
      id_opcode    = 4'h1;
      id_rs        = r.rs;
      id_rt        = r.rt;
      id_uses_rt   = r.uses;
      ex_opcode    = r.ex_op;
      ex_rd        = r.ex_rd;
      mem_opcode   = r.mem_op;
      mem_alu_zero = r.zero;
      dmem_ready   = r.rdy;
      exp_q.push_back(r.exp);
      name_q.push_back(nm);
   endtask

   task automatic test_reset();
      row_t rows[$];
      rows.push_back(mk(1'b1, NOP, 3'd0, 3'd0, 3'd0, 1'b0, NOP, 1'b0, 1'b1, CTL_RST, 2'd0, 0, 0, 1'b0));
      rows.push_back(idle(2'd0, 0, 0, 1'b0));
      rows.push_back(idle(2'd0, 0, 0, 1'b0));
      foreach (rows[i]) begin
         logic [42:0] e;
         string nm;
         apply(rows[i], $sformatf("reset[%0d]", i));
         @(negedge clock);
         e = exp_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL %s got ctl=%b st=%0d sc=%0d fc=%0d err=%b want ctl=%b st=%0d sc=%0d fc=%0d err=%b",
                     nm, obs[42:35], obs[34:33], obs[32:17], obs[16:1], obs[0],
                     e[42:35], e[34:33], e[32:17], e[16:1], e[0]);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_load_use();
      row_t rows[$];
      rows.push_back(mk(1'b0, LD, 3'd3, 3'd3, 3'd0, 1'b0, NOP, 1'b0, 1'b1, CTL_LU,  2'd0, 0, 0, 1'b0));
      rows.push_back(idle(2'd1, 1, 0, 1'b0));
      rows.push_back(mk(1'b0, LD, 3'd0, 3'd0, 3'd0, 1'b1, NOP, 1'b0, 1'b1, CTL_DEF, 2'd0, 1, 0, 1'b0));
      rows.push_back(mk(1'b0, LD, 3'd5, 3'd1, 3'd5, 1'b1, NOP, 1'b0, 1'b1, CTL_LU,  2'd0, 1, 0, 1'b0));
      rows.push_back(mk(1'b0, LD, 3'd5, 3'd1, 3'd5, 1'b0, NOP, 1'b0, 1'b1, CTL_DEF, 2'd1, 2, 0, 1'b0));
      rows.push_back(idle(2'd0, 2, 0, 1'b0));
      rows.push_back(mk(1'b0, LD, 3'd2, 3'd2, 3'd0, 1'b0, NOP, 1'b0, 1'b1, CTL_LU,  2'd0, 2, 0, 1'b0));
      rows.push_back(mk(1'b0, LD, 3'd2, 3'd2, 3'd0, 1'b0, NOP, 1'b0, 1'b1, CTL_LU,  2'd1, 3, 0, 1'b0));
      rows.push_back(idle(2'd1, 4, 0, 1'b0));
      rows.push_back(idle(2'd0, 4, 0, 1'b0));
      foreach (rows[i]) begin
         logic [42:0] e;
         string nm;
         apply(rows[i], $sformatf("load_use[%0d]", i));
         @(negedge clock);
         e = exp_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL %s got ctl=%b st=%0d sc=%0d fc=%0d err=%b want ctl=%b st=%0d sc=%0d fc=%0d err=%b",
                     nm, obs[42:35], obs[34:33], obs[32:17], obs[16:1], obs[0],
                     e[42:35], e[34:33], e[32:17], e[16:1], e[0]);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_redirect();
      row_t rows[$];
      rows.push_back(mk(1'b0, LD, 3'd3, 3'd3, 3'd0, 1'b0, BEQ, 1'b1, 1'b1, CTL_RED, 2'd0, 4, 0, 1'b0));
      rows.push_back(idle(2'd3, 4, 1, 1'b0));
      rows.push_back(mk(1'b0, LD, 3'd3, 3'd3, 3'd0, 1'b0, BEQ, 1'b0, 1'b1, CTL_LU,  2'd0, 4, 1, 1'b0));
      rows.push_back(mk(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, JMP, 1'b0, 1'b1, CTL_RED, 2'd1, 5, 1, 1'b0));
      rows.push_back(idle(2'd3, 5, 2, 1'b0));
      rows.push_back(idle(2'd0, 5, 2, 1'b0));
      foreach (rows[i]) begin
         logic [42:0] e;
         string nm;
         apply(rows[i], $sformatf("redirect[%0d]", i));
         @(negedge clock);
         e = exp_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL %s got ctl=%b st=%0d sc=%0d fc=%0d err=%b want ctl=%b st=%0d sc=%0d fc=%0d err=%b",
                     nm, obs[42:35], obs[34:33], obs[32:17], obs[16:1], obs[0],
                     e[42:35], e[34:33], e[32:17], e[16:1], e[0]);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_mem_wait();
      row_t rows[$];
      rows.push_back(mk(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, LD, 1'b0, 1'b0, CTL_HOLD, 2'd0, 5, 2, 1'b0));
      rows.push_back(mk(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, LD, 1'b0, 1'b0, CTL_HOLD, 2'd2, 6, 2, 1'b0));
      rows.push_back(mk(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, LD, 1'b0, 1'b0, CTL_HOLD, 2'd2, 7, 2, 1'b0));
      rows.push_back(mk(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, LD, 1'b0, 1'b1, CTL_DEF,  2'd2, 8, 2, 1'b0));
      rows.push_back(idle(2'd0, 8, 2, 1'b0));
      foreach (rows[i]) begin
         logic [42:0] e;
         string nm;
         apply(rows[i], $sformatf("mem_wait[%0d]", i));
         @(negedge clock);
         e = exp_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL %s got ctl=%b st=%0d sc=%0d fc=%0d err=%b want ctl=%b st=%0d sc=%0d fc=%0d err=%b",
                     nm, obs[42:35], obs[34:33], obs[32:17], obs[16:1], obs[0],
                     e[42:35], e[34:33], e[32:17], e[16:1], e[0]);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_timeout();
      row_t rows[$];
      // Entry cycle in RUN, then 16 cycles in MEM_WAIT; the 16th releases on timeout.
      rows.push_back(mk(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, ST, 1'b0, 1'b0, CTL_HOLD, 2'd0, 8, 2, 1'b0));
      for (int k = 2; k <= 16; k++)
         rows.push_back(mk(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, ST, 1'b0, 1'b0, CTL_HOLD, 2'd2, 8 + k - 1, 2, 1'b0));
      rows.push_back(mk(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, ST, 1'b0, 1'b0, CTL_DEF, 2'd2, 24, 2, 1'b0));
      rows.push_back(idle(2'd0, 24, 2, 1'b1));
      rows.push_back(idle(2'd0, 24, 2, 1'b1));
      foreach (rows[i]) begin
         logic [42:0] e;
         string nm;
         apply(rows[i], $sformatf("timeout[%0d]", i));
         @(negedge clock);
         e = exp_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL %s got ctl=%b st=%0d sc=%0d fc=%0d err=%b want ctl=%b st=%0d sc=%0d fc=%0d err=%b",
                     nm, obs[42:35], obs[34:33], obs[32:17], obs[16:1], obs[0],
                     e[42:35], e[34:33], e[32:17], e[16:1], e[0]);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset_mid_event();
      row_t rows[$];
      rows.push_back(mk(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, LD, 1'b0, 1'b0, CTL_HOLD, 2'd0, 24, 2, 1'b1));
      rows.push_back(mk(1'b0, NOP, 3'd0, 3'd0, 3'd0, 1'b0, LD, 1'b0, 1'b0, CTL_HOLD, 2'd2, 25, 2, 1'b1));
      rows.push_back(mk(1'b1, NOP, 3'd0, 3'd0, 3'd0, 1'b0, LD, 1'b0, 1'b0, CTL_RST,  2'd2, 26, 2, 1'b1));
      rows.push_back(idle(2'd0, 0, 0, 1'b0));
      rows.push_back(mk(1'b0, LD, 3'd3, 3'd3, 3'd0, 1'b0, NOP, 1'b0, 1'b1, CTL_LU,  2'd0, 0, 0, 1'b0));
      rows.push_back(mk(1'b1, LD, 3'd3, 3'd3, 3'd0, 1'b0, NOP, 1'b0, 1'b1, CTL_RST, 2'd1, 1, 0, 1'b0));
      rows.push_back(idle(2'd0, 0, 0, 1'b0));
      foreach (rows[i]) begin
         logic [42:0] e;
         string nm;
         apply(rows[i], $sformatf("reset_mid[%0d]", i));
         @(negedge clock);
         e = exp_q.pop_front(); nm = name_q.pop_front();
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL %s got ctl=%b st=%0d sc=%0d fc=%0d err=%b want ctl=%b st=%0d sc=%0d fc=%0d err=%b",
                     nm, obs[42:35], obs[34:33], obs[32:17], obs[16:1], obs[0],
                     e[42:35], e[34:33], e[32:17], e[16:1], e[0]);
         end
         @(posedge clock); #1;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got time=%0t required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset        = 1'b1;
      id_opcode    = 4'h0;
      id_rs        = 3'd0;
      id_rt        = 3'd0;
      id_uses_rt   = 1'b0;
      ex_opcode    = NOP;
      ex_rd        = 3'd0;
      mem_opcode   = NOP;
      mem_alu_zero = 1'b0;
      dmem_ready   = 1'b1;
      @(posedge clock); #1;
      test_reset();
      test_load_use();
      test_redirect();
      test_mem_wait();
      test_timeout();
      test_reset_mid_event();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
